// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants,
// used by both the transmit and receive ends of the link.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_CLK-1 and flags the last cycle of each bit.
// Reusable by the receiver.
module uart_bit_timer #(
  parameter int BIT_CLK = 87
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(BIT_CLK);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CLK - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

  assign last = (count == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gap-free frames.
// Handshake: a byte moves on every rising edge where tx_valid && tx_ready; tx_ready depends only on registers.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_CLK = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       cts,
  output logic       txd,
  output logic       busy
);

  uart_state_e state;
  logic [7:0]  hold;
  logic        hold_full;
  logic [7:0]  shift;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  logic        bit_last;

  // Timer is held at zero while idle so the start bit always gets a full period.
  uart_bit_timer #(.BIT_CLK(BIT_CLK)) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .en    (1'b1),
    .last  (bit_last)
  );

  assign tx_ready = ~hold_full;
  assign idx_nxt  = idx + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      txd       <= 1'b1;
      busy      <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      idx       <= '0;
    end else begin
      // Accept and hold->shift transfer are mutually exclusive on hold_full.
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          txd  <= 1'b1;
          busy <= 1'b0;
          if (hold_full && cts) begin
            shift     <= hold;
            hold_full <= 1'b0;
            state     <= START;
            txd       <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (bit_last) begin
            state <= DATA;
            idx   <= '0;
            txd   <= shift[0];
          end
        end
        DATA: begin
          if (bit_last) begin
            if (idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              idx <= idx_nxt;
              txd <= shift[idx_nxt];
            end
          end
        end
        STOP: begin
          if (bit_last) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (hold_full && cts) begin
              shift     <= hold;
              hold_full <= 1'b0;
              state     <= START;
              txd       <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (BIT_CLK 4, 2, 256) share stimulus;
// expected line waveforms come from a frame-level model of the 8N1 format.
module tb_uart_tx;

  localparam int BC0 = 4;
  localparam int BC1 = 2;
  localparam int BC2 = 256;
  localparam int WMAX = 2560;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       cts = 1'b1;
  logic [2:0] txd_v, busy_v, rdy_v;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.BIT_CLK(BC0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_v[0]), .cts(cts), .txd(txd_v[0]), .busy(busy_v[0])
  );
  uart_tx #(.BIT_CLK(BC1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_v[1]), .cts(cts), .txd(txd_v[1]), .busy(busy_v[1])
  );
  uart_tx #(.BIT_CLK(BC2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_v[2]), .cts(cts), .txd(txd_v[2]), .busy(busy_v[2])
  );

  function automatic int bc_of(input int i);
    return (i == 0) ? BC0 : (i == 1) ? BC1 : BC2;
  endfunction

  // Line level per cycle for one frame: bit k of {start, d0..d7, stop} lasts bc cycles.
  function automatic logic [WMAX-1:0] model_wave(input logic [7:0] b, input int bc);
    logic [WMAX-1:0] w;
    int k;
    w = '0;
    for (int c = 0; c < 10 * bc; c++) begin
      k = c / bc;
      if (k == 0)      w[c] = 1'b0;
      else if (k == 9) w[c] = 1'b1;
      else             w[c] = b[k-1];
    end
    return w;
  endfunction

  function automatic int first_diff(input logic [WMAX-1:0] a, input logic [WMAX-1:0] b);
    for (int c = 0; c < WMAX; c++) if (a[c] !== b[c]) return c;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_valid = 1'b0;
    cts = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int i, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (txd_v[i] === 1'b0) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  // Records txd/tx_ready for n cycles starting at the current cycle; counts busy cycles.
  task automatic capture(input int i, input int n, output logic [WMAX-1:0] wave,
                         output logic [WMAX-1:0] rdyw, output int bcnt);
    wave = '0;
    rdyw = '0;
    bcnt = 0;
    for (int c = 0; c < n; c++) begin
      wave[c] = txd_v[i];
      rdyw[c] = rdy_v[i];
      if (busy_v[i] === 1'b1) bcnt++;
      step();
    end
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    tests++;
    if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: txd=%b busy=%b tx_ready=%b, required 1 0 1",
               txd_v[0], busy_v[0], rdy_v[0]);
    end
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_100: %0d bad idle cycles, required 0", bad);
    end
  endtask

  task automatic test_send_a5();
    logic [WMAX-1:0] w, r, e;
    int bcnt;
    do_reset();
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tests++;
    if (rdy_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL a5_hold_full: tx_ready=%b, required 0", rdy_v[0]);
    end
    step();
    tests++;
    if (txd_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || rdy_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL a5_first_start: txd=%b busy=%b tx_ready=%b, required 0 1 1",
               txd_v[0], busy_v[0], rdy_v[0]);
    end
    capture(0, 10 * BC0, w, r, bcnt);
    e = model_wave(8'hA5, BC0);
    tests++;
    if (w !== e) begin
      fails++;
      $display("FAIL a5_wave: first difference at cycle %0d, txd=%b required %b",
               first_diff(w, e), w[first_diff(w, e)], e[first_diff(w, e)]);
    end
    tests++;
    if (bcnt != 40 || busy_v[0] !== 1'b0 || txd_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL a5_busy: busy cycles=%0d busy_after=%b txd_after=%b, required 40 0 1",
               bcnt, busy_v[0], txd_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [WMAX-1:0] w, r, e;
    int bcnt;
    bit ok;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h55;
    do_reset();
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          int n;
          tx_data = bytes[k];
          tx_valid = 1'b1;
          n = 0;
          while (rdy_v[0] !== 1'b1 && n < 200) begin
            step();
            n++;
          end
          step();
        end
        tx_valid = 1'b0;
      end
      begin
        wait_start(0, 20, ok);
        tests++;
        if (!ok) begin
          fails++;
          $display("FAIL b2b_start: start bit not seen within 20 cycles");
        end
        capture(0, 30 * BC0, w, r, bcnt);
      end
    join
    e = model_wave(bytes[0], BC0) | (model_wave(bytes[1], BC0) << 40)
      | (model_wave(bytes[2], BC0) << 80);
    tests++;
    if (w !== e) begin
      fails++;
      $display("FAIL b2b_wave: first difference at cycle %0d, txd=%b required %b",
               first_diff(w, e), w[first_diff(w, e)], e[first_diff(w, e)]);
    end
    tests++;
    if (bcnt != 120) begin
      fails++;
      $display("FAIL b2b_busy: busy cycles=%0d, required 120", bcnt);
    end
    tests++;
    if (r[20] !== 1'b0 || r[60] !== 1'b0 || r[100] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready: tx_ready at cycles 20/60/100 = %b%b%b, required 001",
               r[20], r[60], r[100]);
    end
  endtask

  task automatic test_cts();
    logic [WMAX-1:0] w, r, e;
    int bcnt, bad;
    do_reset();
    cts = 1'b0;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL cts_hold_off: %0d cycles not idle-with-hold-full, required 0", bad);
    end
    cts = 1'b1;
    step();
    tests++;
    if (txd_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL cts_release: txd=%b busy=%b, required 0 1", txd_v[0], busy_v[0]);
    end
    fork
      capture(0, 10 * BC0, w, r, bcnt);
      begin
        repeat (15) step();
        cts = 1'b0;
      end
    join
    e = model_wave(8'h3C, BC0);
    tests++;
    if (w !== e || bcnt != 40) begin
      fails++;
      $display("FAIL cts_drop_mid: first diff cycle %0d, busy cycles=%0d, required no diff and 40",
               first_diff(w, e), bcnt);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bit ok;
    do_reset();
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    wait_start(0, 10, ok);
    repeat (14) step();
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tests++;
    if (!ok || rdy_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_setup: started=%0d tx_ready=%b busy=%b, required 1 0 1",
               ok, rdy_v[0], busy_v[0]);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++;
    if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: txd=%b busy=%b tx_ready=%b, required 1 0 1",
               txd_v[0], busy_v[0], rdy_v[0]);
    end
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mid_no_frame: %0d non-idle cycles after reset, required 0", bad);
    end
  endtask

  task automatic test_random();
    localparam int N = 8;
    logic [WMAX-1:0] w, r, e;
    logic [7:0] b;
    int bcnt;
    bit ok;
    do_reset();
    exp_q.delete();
    fork
      begin
        for (int k = 0; k < N; k++) begin
          int n;
          repeat ($urandom_range(0, 50)) step();
          b = 8'($urandom);
          tx_data = b;
          tx_valid = 1'b1;
          n = 0;
          while (rdy_v[0] !== 1'b1 && n < 200) begin
            step();
            n++;
          end
          step();
          exp_q.push_back(b);
          tx_valid = 1'b0;
        end
      end
      begin
        for (int k = 0; k < N; k++) begin
          wait_start(0, 400, ok);
          tests++;
          if (!ok || exp_q.size() == 0) begin
            fails++;
            $display("FAIL rand_start: frame %0d started=%0d queued=%0d, required 1 and >0",
                     k, ok, exp_q.size());
            break;
          end
          capture(0, 10 * BC0, w, r, bcnt);
          e = model_wave(exp_q.pop_front(), BC0);
          tests++;
          if (w !== e) begin
            fails++;
            $display("FAIL rand_wave: frame %0d first difference at cycle %0d, txd=%b required %b",
                     k, first_diff(w, e), w[first_diff(w, e)], e[first_diff(w, e)]);
          end
        end
      end
    join
  endtask

  task automatic test_lengths();
    logic [WMAX-1:0] w, r, e;
    logic [7:0] b;
    int bcnt;
    bit ok;
    for (int i = 1; i < 3; i++) begin
      do_reset();
      b = 8'($urandom);
      tx_data = b;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      wait_start(i, 10, ok);
      capture(i, 10 * bc_of(i), w, r, bcnt);
      e = model_wave(b, bc_of(i));
      tests++;
      if (!ok || w !== e) begin
        fails++;
        $display("FAIL len_wave_bc%0d: started=%0d first difference at cycle %0d",
                 bc_of(i), ok, first_diff(w, e));
      end
      tests++;
      if (bcnt != 10 * bc_of(i) || busy_v[i] !== 1'b0 || txd_v[i] !== 1'b1) begin
        fails++;
        $display("FAIL len_busy_bc%0d: busy cycles=%0d busy_after=%b, required %0d and 0",
                 bc_of(i), bcnt, busy_v[i], 10 * bc_of(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_send_a5();
    test_back_to_back();
    test_cts();
    test_reset_mid();
    test_random();
    test_lengths();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
